sparse_mult_scheduler: RTL

// Sequences xor_adder to compute acc += sparse * dense over GF(2)[x]/(x^(N_WORDS*WORD_WIDTH)-1).

---
 rtl/sparse_mult_scheduler.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sparse_mult_scheduler.sv
// Drives a combinational xor_adder so that acc += sparse * dense over GF(2)[x]/(x^(N_WORDS*WORD_WIDTH)-1).
// Sparse positions are consumed two per pass; each pass sweeps every acc word as read-dense / read-acc / write.
module sparse_mult_scheduler #(
  parameter int WORD_WIDTH = 32,
  parameter int N_WORDS    = 64,
  parameter int ADDR_W     = 6,
  parameter int WEIGHT     = 66,
  parameter int PADDR_W    = 7,
  parameter int POS_W      = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear_acc,
  output logic                  busy,
  output logic                  done,
  output logic                  pos_rd_en,
  output logic [PADDR_W-1:0]    pos_rd_addr,
  input  logic [POS_W-1:0]      pos_rd_data,
  output logic [ADDR_W-1:0]     dense_rd_addr0,
  output logic [ADDR_W-1:0]     dense_rd_addr1,
  input  logic [WORD_WIDTH-1:0] dense_rd_data0,
  input  logic [WORD_WIDTH-1:0] dense_rd_data1,
  output logic [ADDR_W-1:0]     acc_rd_addr,
  input  logic [WORD_WIDTH-1:0] acc_rd_data,
  output logic                  acc_wr_en,
  output logic [ADDR_W-1:0]     acc_wr_addr,
  output logic [WORD_WIDTH-1:0] acc_wr_data,
  output logic [WORD_WIDTH-1:0] normal_high_word_left,
  output logic [WORD_WIDTH-1:0] normal_high_word_right,
  output logic [WORD_WIDTH-1:0] normal_low_word_left,
  output logic [WORD_WIDTH-1:0] normal_low_word_right,
  output logic [WORD_WIDTH-1:0] acc_poly,
  output logic [5:0]            normal_start,
  output logic [5:0]            sparse_start,
  input  logic [WORD_WIDTH-1:0] result
);

  localparam int SH = $clog2(WORD_WIDTH);

  typedef enum logic [2:0] {IDLE, RD_PA, RD_PB, CALC, RD_HI, RD_LO, WR, DONE} state_t;

  state_t              state, next;
  logic [PADDR_W:0]    k;
  logic [PADDR_W:0]    k_inc;
  logic [PADDR_W:0]    k_next;
  logic [ADDR_W-1:0]   j;
  logic [ADDR_W-1:0]   q_a, q_b;
  logic [5:0]          start_a, start_b;
  logic                vld_b;
  logic                clr_r;
  logic                b_avail;
  logic                more;
  logic                last_j;
  logic [WORD_WIDTH-1:0] hi_left_p1, hi_right_p1;

  // (a - b) mod N_WORDS for a < N_WORDS, b <= N_WORDS
  function automatic logic [ADDR_W-1:0] sub_mod(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W:0]   b);
    logic [ADDR_W+1:0] d;
    d = {2'b00, a} - {1'b0, b};
    if (d[ADDR_W+1]) d = d + (ADDR_W+2)'(N_WORDS);
    return d[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] word_of(input logic [POS_W-1:0] p);
    return ADDR_W'(p >> SH);
  endfunction

  // Bit offset handed to the adder: WORD_WIDTH - r, so r = 0 maps to WORD_WIDTH
  function automatic logic [5:0] start_of(input logic [POS_W-1:0] p);
    return 6'(WORD_WIDTH - int'(p[SH-1:0]));
  endfunction

  assign k_inc   = k + (PADDR_W+1)'(1);
  assign k_next  = k + (PADDR_W+1)'(2);
  assign b_avail = 32'(k_inc) < 32'(WEIGHT);
  assign more    = 32'(k_next) < 32'(WEIGHT);
  assign last_j  = (j == ADDR_W'(N_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next           = state;
    busy           = 1'b0;
    done           = 1'b0;
    pos_rd_en      = 1'b0;
    pos_rd_addr    = '0;
    dense_rd_addr0 = '0;
    dense_rd_addr1 = '0;
    acc_rd_addr    = '0;
    acc_wr_en      = 1'b0;
    acc_wr_addr    = '0;
    case (state)
      IDLE: if (start) next = RD_PA;
      RD_PA: begin
        busy        = 1'b1;
        pos_rd_en   = 1'b1;
        pos_rd_addr = k[PADDR_W-1:0];
        next        = RD_PB;
      end
      RD_PB: begin
        busy      = 1'b1;
        pos_rd_en = b_avail;
        if (b_avail) pos_rd_addr = k_inc[PADDR_W-1:0];
        next      = CALC;
      end
      CALC: begin
        busy = 1'b1;
        next = RD_HI;
      end
      RD_HI: begin
        busy           = 1'b1;
        dense_rd_addr0 = sub_mod(j, {1'b0, q_a});
        dense_rd_addr1 = sub_mod(j, (ADDR_W+1)'(q_a) + (ADDR_W+1)'(1));
        next           = RD_LO;
      end
      RD_LO: begin
        busy           = 1'b1;
        dense_rd_addr0 = sub_mod(j, {1'b0, q_b});
        dense_rd_addr1 = sub_mod(j, (ADDR_W+1)'(q_b) + (ADDR_W+1)'(1));
        acc_rd_addr    = j;
        next           = WR;
      end
      WR: begin
        busy        = 1'b1;
        acc_wr_en   = 1'b1;
        acc_wr_addr = j;
        if (!last_j)   next = RD_HI;
        else if (more) next = RD_PA;
        else           next = DONE;
      end
      DONE: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k           <= '0;
      j           <= '0;
      q_a         <= '0;
      q_b         <= '0;
      start_a     <= '0;
      start_b     <= '0;
      vld_b       <= 1'b0;
      clr_r       <= 1'b0;
      hi_left_p1  <= '0;
      hi_right_p1 <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          k     <= '0;
          clr_r <= clear_acc;
        end
        RD_PB: begin
          q_a     <= word_of(pos_rd_data);
          start_a <= start_of(pos_rd_data);
          vld_b   <= b_avail;
        end
        CALC: begin
          j <= '0;
          if (vld_b) begin
            q_b     <= word_of(pos_rd_data);
            start_b <= start_of(pos_rd_data);
          end else begin
            q_b     <= '0;
            start_b <= 6'(WORD_WIDTH);
          end
        end
        // stage p1: pair-A words held while pair-B words are in flight
        RD_LO: begin
          hi_left_p1  <= dense_rd_data0;
          hi_right_p1 <= dense_rd_data1;
        end
        WR: begin
          j <= j + ADDR_W'(1);
          if (last_j) begin
            k     <= k_next;
            clr_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign normal_high_word_left  = hi_left_p1;
  assign normal_high_word_right = hi_right_p1;
  assign normal_low_word_left   = (state == WR && vld_b) ? dense_rd_data0 : '0;
  assign normal_low_word_right  = (state == WR && vld_b) ? dense_rd_data1 : '0;
  assign acc_poly               = (state == WR && !clr_r) ? acc_rd_data : '0;
  assign acc_wr_data            = (state == WR) ? result : '0;
  assign normal_start           = start_a;
  assign sparse_start           = start_b;

endmodule
